// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: shares one cache_memory request/response port between
// NUM_REQ requesters. Requests are granted round-robin; the winner's index is
// queued in an in-order ID FIFO so each response is routed back to its issuer.

// Per-requester handshake decode: request accept and response valid.
module cache_req_arbiter_lane #(
    parameter int IDW = 1,
    parameter int ID  = 0
) (
    input  logic [IDW-1:0] grant_i,
    input  logic [IDW-1:0] head_i,
    input  logic           issue_en_i,
    input  logic           resp_en_i,
    output logic           req_ready_o,
    output logic           resp_valid_o
);
    assign req_ready_o  = issue_en_i & (grant_i == IDW'(ID));
    assign resp_valid_o = resp_en_i  & (head_i  == IDW'(ID));
endmodule

module cache_req_arbiter #(
    parameter  int NUM_REQ   = 2,
    parameter  int REQ_W     = 128,
    parameter  int RESP_W    = 128,
    parameter  int MAX_OUTST = 4,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int PW        = $clog2(MAX_OUTST),
    localparam int CW        = $clog2(MAX_OUTST + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*REQ_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       resp_valid_o,
    input  logic [NUM_REQ-1:0]       resp_ready_i,
    output logic [RESP_W-1:0]        resp_data_o,
    output logic                     cache_req_valid_o,
    input  logic                     cache_req_ready_i,
    output logic [REQ_W-1:0]         cache_req_o,
    input  logic                     cache_resp_valid_i,
    output logic                     cache_resp_ready_o,
    input  logic [RESP_W-1:0]        cache_resp_i,
    output logic [CW-1:0]            outstanding_o,
    output logic                     busy_o,
    output logic                     err_orphan_resp_o
);

    logic [NUM_REQ-1:0][REQ_W-1:0]   req_data_v;
    logic [IDW-1:0]                  rr_ptr_q, rr_ptr_d;
    logic                            lock_q, lock_d;
    logic [IDW-1:0]                  lock_id_q, lock_id_d;
    logic [MAX_OUTST-1:0][IDW-1:0]   fifo_q;
    logic [PW:0]                     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            err_q;

    logic [IDW-1:0]                  rr_gnt, grant, head;
    logic                            rr_hit, gnt_vld;
    logic                            fifo_full, fifo_empty;
    logic                            push, pop, issue_en, resp_en;
    int                              idx;

    assign req_data_v = req_data_i;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head       = fifo_q[rd_ptr_q[PW-1:0]];

    // Round-robin search over req_valid starting at rr_ptr.
    always_comb begin
        rr_gnt = '0;
        rr_hit = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!rr_hit && req_valid_i[IDW'(idx)]) begin
                rr_gnt = IDW'(idx);
                rr_hit = 1'b1;
            end
        end
    end

    // A stalled grant is pinned so the cache sees a stable request.
    assign grant   = lock_q ? lock_id_q : rr_gnt;
    assign gnt_vld = lock_q ? req_valid_i[lock_id_q] : rr_hit;

    // Full is judged on registered state: a same-cycle pop does not free a slot.
    assign cache_req_valid_o = gnt_vld & ~fifo_full;
    assign cache_req_o       = req_data_v[grant];
    assign issue_en          = gnt_vld & cache_req_ready_i & ~fifo_full;
    assign push              = cache_req_valid_o & cache_req_ready_i;

    // Empty FIFO: any response is an orphan and is drained unconditionally.
    assign cache_resp_ready_o = fifo_empty ? cache_resp_valid_i : resp_ready_i[head];
    assign resp_en            = cache_resp_valid_i & ~fifo_empty;
    assign pop                = resp_en & cache_resp_ready_o;
    assign resp_data_o        = cache_resp_i;

    assign outstanding_o     = cnt_q;
    assign busy_o            = (cnt_q != '0) | cache_req_valid_o;
    assign err_orphan_resp_o = err_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        cache_req_arbiter_lane #(.IDW(IDW), .ID(i)) u_lane (
            .grant_i      (grant),
            .head_i       (head),
            .issue_en_i   (issue_en),
            .resp_en_i    (resp_en),
            .req_ready_o  (req_ready_o[i]),
            .resp_valid_o (resp_valid_o[i])
        );
    end

    // Next-state for round-robin pointer, lock and in-flight count.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        cnt_d     = cnt_q;
        if (push) begin
            rr_ptr_d = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + IDW'(1);
            lock_d   = 1'b0;
        end else if (cache_req_valid_o && !cache_req_ready_i) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers, ID FIFO storage and sticky orphan flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            fifo_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            cnt_q     <= cnt_d;
            if (push) begin
                fifo_q[wr_ptr_q[PW-1:0]] <= grant;
                wr_ptr_q                 <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (cache_resp_valid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    // A stalled requester must keep valid high and its payload unchanged.
    a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (cache_req_valid_o && !cache_req_ready_i) |=>
        (req_valid_i[lock_id_q] && $stable(cache_req_o)));

endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- Shares the single cache_memory request/response port between NUM_REQ requesters, e.g. control_unit and a UCIe-side prefetch/DMA path.
- Arbitrates requests round-robin and records the winner's index in an in-order ID FIFO.
- Routes each cache response back to the requester at the FIFO head.
- Sits between the requesters and cache_memory in nmcu_chiplet; cache_memory returns exactly one response per accepted request, in order.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
REQ_W, 128, width of a request payload (packed cache_req_t)
RESP_W, 128, width of a response payload (packed cache_resp_t)
MAX_OUTST, 4, ID FIFO depth = max requests in flight (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accept
req_data  in  NUM_REQ*REQ_W  requester i payload at [i*REQ_W +: REQ_W]
resp_valid  out  NUM_REQ  per-requester response valid
resp_ready  in  NUM_REQ  per-requester response accept
resp_data  out  RESP_W  response payload, broadcast to all requesters
cache_req_valid  out  1  request to cache_memory
cache_req_ready  in  1  cache_memory accepts request
cache_req  out  REQ_W  payload to cache_memory
cache_resp_valid  in  1  response from cache_memory
cache_resp_ready  out  1  arbiter accepts response
cache_resp  in  RESP_W  response payload
outstanding  out  $clog2(MAX_OUTST+1)  requests issued but not yet responded
busy  out  1  outstanding!=0 or cache_req_valid
err_orphan_resp  out  1  sticky: response arrived while ID FIFO empty

Behaviour:
- Reset (async, rst_n=0): rr_ptr=0, lock=0, FIFO empty, outstanding=0, err_orphan_resp=0. Outputs are combinational from this state, so req_ready=0, cache_req_valid=0, resp_valid=0, cache_resp_ready=0, busy=0.
- Reset mid-transaction drops all in-flight state. No replay is performed.
- Arbitration:
  - Combinational round-robin over req_valid, starting at rr_ptr.
  - The winner g drives cache_req=req_data[g] and cache_req_valid=1, but only if the FIFO is not full.
  - Zero-cycle latency from req_valid to cache_req_valid.
- Lock:
  - If cache_req_valid=1 and cache_req_ready=0, set lock=1 and lock_id=g.
  - While lock=1, the grant stays at lock_id regardless of other req_valid bits.
  - Requesters must hold valid and data stable until ready (AXI-style rule). An assertion checks this.
- Issue handshake:
  - req_ready[i]=(i==grant) & cache_req_ready & ~fifo_full.
  - On handshake: push g into the FIFO, rr_ptr<=(g+1) mod NUM_REQ, lock<=0.
- FIFO full:
  - cache_req_valid=0 and all req_ready=0.
  - A pop in the same cycle does not unblock issue. Issue resumes the next cycle.
- Response routing:
  - h=FIFO head.
  - resp_valid[i]=cache_resp_valid & ~fifo_empty & (i==h).
  - cache_resp_ready=resp_ready[h] when the FIFO is non-empty.
  - resp_data=cache_resp.
  - Pop on cache_resp_valid & cache_resp_ready.
- Orphan response:
  - FIFO empty and cache_resp_valid=1 → cache_resp_ready=1 (drained), no resp_valid, err_orphan_resp<=1.
  - Cleared only by reset.
- Counter: outstanding +1 on push, -1 on pop, unchanged on simultaneous push and pop. Never exceeds MAX_OUTST.
- FIFO pointers use log2(MAX_OUTST) bits plus a wrap bit and wrap naturally.
- Simultaneous issue and response to the same requester are independent; both complete in the same cycle.

Test Plan:
- NUM_REQ=2, MAX_OUTST=4: req0 alone, cache_req_ready=1 → cache_req=req_data[0] same cycle, outstanding=1. Response one cycle later → resp_valid[0]=1, outstanding=0.
- req0 and req1 held continuously valid, ready=1 → grants alternate 0,1,0,1. After 4 issues with no responses, FIFO is full: req_ready=00, cache_req_valid=0, outstanding=4.
- req0 wins with cache_req_ready=0 for 3 cycles while req1 asserts → grant stays 0 and cache_req holds req_data[0]. Ready on cycle 4 → req0 issued, then req1 granted next.
- Issue order 1,0,1 with responses R_a,R_b,R_c → resp_valid pulses to 1,0,1 in order. Stalling resp_ready[0] for 2 cycles holds cache_resp_ready=0 for those cycles.
- Full FIFO with a response popped in the same cycle as a pending request → no issue that cycle, issue next cycle; outstanding goes 4→3→4.
- cache_resp_valid with an empty FIFO → cache_resp_ready=1, err_orphan_resp=1 and stays sticky. rst_n pulse mid-flight with outstanding=3 → all outputs reset, outstanding=0, flag cleared.
